// File: rtl/core_pkg.sv
// Shared writeback types: result-source select, load size and the held writeback entry.
package core_pkg;

   // Entry fields are sized for the widest supported core; narrower cores use the low bits.
   localparam int WB_DATA_W = 64;
   localparam int WB_RD_W   = 5;

   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_t;

   typedef enum logic [1:0] {MSZ_B, MSZ_H, MSZ_W, MSZ_D} mem_size_t;

   typedef struct packed {
      logic [WB_RD_W-1:0]   rd;
      logic                 rd_we;
      logic [WB_DATA_W-1:0] data;
      logic [WB_DATA_W-1:0] pc;
   } wb_entry_t;

endpackage

// File: rtl/load_extend.sv
// Aligns a sub-word load from its byte offset and sign- or zero-extends it to XLEN.
module load_extend
   import core_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int OFF_W = $clog2(XLEN/8)
)(
   input  logic [XLEN-1:0]  data,
   input  logic [OFF_W-1:0] off,
   input  mem_size_t        size,
   input  logic             uns,
   output logic [XLEN-1:0]  result
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;
   logic            sign;

   assign shifted = data >> {off, 3'b000};

   // Masking instead of replication keeps the word case legal when XLEN is 32 (D behaves as W).
   always_comb begin
      mask = '1;
      sign = 1'b0;
      unique case (size)
         MSZ_B: begin
            mask = XLEN'(32'h0000_00FF);
            sign = shifted[7];
         end
         MSZ_H: begin
            mask = XLEN'(32'h0000_FFFF);
            sign = shifted[15];
         end
         MSZ_W: begin
            mask = XLEN'(32'hFFFF_FFFF);
            sign = shifted[31];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
   end

   assign result = (shifted & mask) | ({XLEN{sign & ~uns}} & ~mask);

endmodule

// File: rtl/writeback_unit.sv
// Registered writeback stage: selects the result, holds one entry, drives regfile write,
// forwarding tap and commit stream, and counts retired instructions.
module writeback_unit
   import core_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int RETIRE_W = 64,
   parameter int REG_AW   = 5
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  wb_sel_t                    in_wb_sel,
   input  logic [REG_AW-1:0]          in_rd,
   input  logic                       in_rd_we,
   input  logic [XLEN-1:0]            in_alu,
   input  logic [XLEN-1:0]            in_mem_data,
   input  logic [$clog2(XLEN/8)-1:0]  in_mem_off,
   input  mem_size_t                  in_mem_size,
   input  logic                       in_mem_uns,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [XLEN-1:0]            in_csr,
   output logic                       rf_we,
   output logic [REG_AW-1:0]          rf_waddr,
   output logic [XLEN-1:0]            rf_wdata,
   output logic                       fwd_valid,
   output logic [REG_AW-1:0]          fwd_rd,
   output logic [XLEN-1:0]            fwd_data,
   output logic                       commit_valid,
   input  logic                       commit_ready,
   output logic [XLEN-1:0]            commit_pc,
   output logic [RETIRE_W-1:0]        retire_cnt
);

   logic            held_valid;
   wb_entry_t       held;
   wb_entry_t       next_entry;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] sel_data;
   logic            accept;
   logic            commit_fire;
   logic            held_writes;

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .data   (in_mem_data),
      .off    (in_mem_off),
      .size   (in_mem_size),
      .uns    (in_mem_uns),
      .result (load_data)
   );

   // The slot frees in the same cycle it commits, so a steady stream sees no bubbles.
   assign in_ready    = !held_valid || commit_ready;
   assign accept      = in_valid && in_ready;
   assign commit_fire = held_valid && commit_ready;

   always_comb begin
      sel_data = in_alu;
      unique case (in_wb_sel)
         WB_ALU:  sel_data = in_alu;
         WB_MEM:  sel_data = load_data;
         WB_PC4:  sel_data = in_pc + XLEN'(4);
         WB_CSR:  sel_data = in_csr;
         default: sel_data = in_alu;
      endcase
   end

   always_comb begin
      next_entry       = '0;
      next_entry.rd    = WB_RD_W'(in_rd);
      next_entry.rd_we = in_rd_we;
      next_entry.data  = WB_DATA_W'(sel_data);
      next_entry.pc    = WB_DATA_W'(in_pc);
   end

   // A new accept overwrites the slot even when the old entry commits on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         held_valid <= 1'b0;
         held       <= '0;
         retire_cnt <= '0;
      end else begin
         if (accept) begin
            held_valid <= 1'b1;
            held       <= next_entry;
         end else if (commit_fire) begin
            held_valid <= 1'b0;
         end
         if (commit_fire) begin
            retire_cnt <= retire_cnt + RETIRE_W'(1);
         end
      end
   end

   // x0 is hardwired zero, so it is never written nor advertised for forwarding.
   assign held_writes  = held.rd_we && (held.rd[REG_AW-1:0] != '0);

   assign commit_valid = held_valid;
   assign commit_pc    = held.pc[XLEN-1:0];
   assign rf_we        = commit_fire && held_writes;
   assign rf_waddr     = held.rd[REG_AW-1:0];
   assign rf_wdata     = held.data[XLEN-1:0];
   assign fwd_valid    = held_valid && held_writes;
   assign fwd_rd       = held.rd[REG_AW-1:0];
   assign fwd_data     = held.data[XLEN-1:0];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic against a
// transaction-level model of the hold slot and retire count.
module tb_writeback_unit;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic        inReady;
   wb_sel_t     inWbSel;
   logic [4:0]  inRd;
   logic        inRdWe;
   logic [63:0] inAlu;
   logic [63:0] inMemData;
   logic [2:0]  inMemOff;
   mem_size_t   inMemSize;
   logic        inMemUns;
   logic [63:0] inPc;
   logic [63:0] inCsr;
   logic        rfWe;
   logic [4:0]  rfWaddr;
   logic [63:0] rfWdata;
   logic        fwdValid;
   logic [4:0]  fwdRd;
   logic [63:0] fwdData;
   logic        commitValid;
   logic        commitReady;
   logic [63:0] commitPc;
   logic [63:0] retireCnt;

   bit          mValid;
   logic [4:0]  mRd;
   bit          mWe;
   logic [63:0] mData;
   logic [63:0] mPc;
   logic [63:0] mCnt;
   logic [63:0] cntBefore;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   writeback_unit dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .in_wb_sel    (inWbSel),
      .in_rd        (inRd),
      .in_rd_we     (inRdWe),
      .in_alu       (inAlu),
      .in_mem_data  (inMemData),
      .in_mem_off   (inMemOff),
      .in_mem_size  (inMemSize),
      .in_mem_uns   (inMemUns),
      .in_pc        (inPc),
      .in_csr       (inCsr),
      .rf_we        (rfWe),
      .rf_waddr     (rfWaddr),
      .rf_wdata     (rfWdata),
      .fwd_valid    (fwdValid),
      .fwd_rd       (fwdRd),
      .fwd_data     (fwdData),
      .commit_valid (commitValid),
      .commit_ready (commitReady),
      .commit_pc    (commitPc),
      .retire_cnt   (retireCnt)
   );

   // Expected result from the architectural rules, using arithmetic rather than bit slicing.
   function automatic logic [63:0] refData(input wb_sel_t sel, input logic [63:0] alu,
                                           input logic [63:0] mem, input logic [2:0] off,
                                           input mem_size_t size, input bit uns,
                                           input logic [63:0] pc, input logic [63:0] csr);
      logic [63:0] sh;
      logic [63:0] v;
      sh = mem >> (8 * off);
      case (sel)
         WB_ALU: v = alu;
         WB_PC4: v = pc + 64'd4;
         WB_CSR: v = csr;
         default: begin
            case (size)
               MSZ_B: begin
                  v = sh % 64'd256;
                  if (!uns && v >= 64'd128) v = v - 64'd256;
               end
               MSZ_H: begin
                  v = sh % 64'd65536;
                  if (!uns && v >= 64'd32768) v = v - 64'd65536;
               end
               MSZ_W: begin
                  v = sh % 64'h1_0000_0000;
                  if (!uns && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
               end
               default: v = sh;
            endcase
         end
      endcase
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit v, input wb_sel_t sel, input logic [4:0] rd,
                                input bit we, input logic [63:0] alu, input logic [63:0] mem,
                                input logic [2:0] off, input mem_size_t size, input bit uns,
                                input logic [63:0] pc, input logic [63:0] csr, input bit cr);
      inValid     = v;
      inWbSel     = sel;
      inRd        = rd;
      inRdWe      = we;
      inAlu       = alu;
      inMemData   = mem;
      inMemOff    = off;
      inMemSize   = size;
      inMemUns    = uns;
      inPc        = pc;
      inCsr       = csr;
      commitReady = cr;
   endtask

   task automatic idle(input bit cr);
      applyStimulus(1'b0, WB_ALU, 5'd0, 1'b0, 64'd0, 64'd0, 3'd0, MSZ_B, 1'b0, 64'd0, 64'd0, cr);
   endtask

   // Compare outputs against the model on the falling edge, then advance the model at the rising edge.
   task automatic clockCycle();
      bit fire;
      bit acc;
      @(negedge clk);
      checkOutput("commit_valid", commitValid, mValid);
      checkOutput("in_ready", inReady, !mValid || commitReady);
      checkOutput("rf_we", rfWe, mValid && commitReady && mWe && mRd != 0);
      checkOutput("fwd_valid", fwdValid, mValid && mWe && mRd != 0);
      checkOutput("retire_cnt", retireCnt, mCnt);
      if (mValid) begin
         checkOutput("rf_waddr", rfWaddr, mRd);
         checkOutput("rf_wdata", rfWdata, mData);
         checkOutput("fwd_rd", fwdRd, mRd);
         checkOutput("fwd_data", fwdData, mData);
         checkOutput("commit_pc", commitPc, mPc);
      end
      @(posedge clk);
      if (reset) begin
         mValid = 0;
         mRd    = '0;
         mWe    = 0;
         mData  = '0;
         mPc    = '0;
         mCnt   = '0;
      end else begin
         fire = mValid && commitReady;
         acc  = inValid && (!mValid || commitReady);
         if (fire) mCnt = mCnt + 64'd1;
         if (acc) begin
            mValid = 1;
            mRd    = inRd;
            mWe    = inRdWe;
            mData  = refData(inWbSel, inAlu, inMemData, inMemOff, inMemSize, inMemUns, inPc, inCsr);
            mPc    = inPc;
         end else if (fire) begin
            mValid = 0;
         end
      end
      #1;
   endtask

   initial begin
      reset = 1'b1;
      idle(1'b1);
      @(posedge clk);
      #1;
      mValid = 0; mRd = '0; mWe = 0; mData = '0; mPc = '0; mCnt = '0;
      clockCycle();
      reset = 1'b0;

      $display("[TB] reset then idle");
      for (int i = 0; i < 10; i++) begin
         clockCycle();
         checkOutput("t1_rf_wdata", rfWdata, 64'd0);
         checkOutput("t1_rf_waddr", rfWaddr, 64'd0);
         checkOutput("t1_fwd_data", fwdData, 64'd0);
         checkOutput("t1_commit_pc", commitPc, 64'd0);
         checkOutput("t1_in_ready", inReady, 64'd1);
         checkOutput("t1_retire_cnt", retireCnt, 64'd0);
      end

      $display("[TB] load extension");
      applyStimulus(1'b1, WB_MEM, 5'd3, 1'b1, 64'd0, 64'h8877665544332211, 3'd2, MSZ_H, 1'b0, 64'h100, 64'd0, 1'b1);
      clockCycle();
      checkOutput("t2_half", rfWdata, 64'h0000000000004433);
      applyStimulus(1'b1, WB_MEM, 5'd4, 1'b1, 64'd0, 64'h000000000000F080, 3'd0, MSZ_B, 1'b0, 64'h104, 64'd0, 1'b1);
      clockCycle();
      checkOutput("t2_byte_s", rfWdata, 64'hFFFFFFFFFFFFFF80);
      applyStimulus(1'b1, WB_MEM, 5'd5, 1'b1, 64'd0, 64'h000000000000F080, 3'd0, MSZ_B, 1'b1, 64'h108, 64'd0, 1'b1);
      clockCycle();
      checkOutput("t2_byte_u", rfWdata, 64'h0000000000000080);
      idle(1'b1);
      clockCycle();

      $display("[TB] pc+4");
      applyStimulus(1'b1, WB_PC4, 5'd1, 1'b1, 64'd0, 64'd0, 3'd0, MSZ_B, 1'b0, 64'h80000000, 64'd0, 1'b1);
      clockCycle();
      idle(1'b1);
      #1;
      checkOutput("t3_rf_we", rfWe, 64'd1);
      checkOutput("t3_rf_waddr", rfWaddr, 64'd1);
      checkOutput("t3_rf_wdata", rfWdata, 64'h80000004);
      clockCycle();

      $display("[TB] write to x0");
      cntBefore = mCnt;
      applyStimulus(1'b1, WB_ALU, 5'd0, 1'b1, 64'h1234, 64'd0, 3'd0, MSZ_B, 1'b0, 64'h200, 64'd0, 1'b1);
      clockCycle();
      idle(1'b1);
      #1;
      checkOutput("t4_commit_valid", commitValid, 64'd1);
      checkOutput("t4_rf_we", rfWe, 64'd0);
      checkOutput("t4_fwd_valid", fwdValid, 64'd0);
      clockCycle();
      checkOutput("t4_retire_cnt", retireCnt, cntBefore + 64'd1);

      $display("[TB] backpressure then stream");
      applyStimulus(1'b1, WB_ALU, 5'd7, 1'b1, 64'hAAAA, 64'd0, 3'd0, MSZ_B, 1'b0, 64'h300, 64'd0, 1'b1);
      clockCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, WB_ALU, 5'd8, 1'b1, 64'hB000, 64'd0, 3'd0, MSZ_B, 1'b0, 64'h304, 64'd0, 1'b0);
         #1;
         checkOutput("t5_in_ready", inReady, 64'd0);
         checkOutput("t5_stable_data", rfWdata, 64'hAAAA);
         checkOutput("t5_stable_pc", commitPc, 64'h300);
         clockCycle();
      end
      cntBefore = mCnt;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, WB_ALU, 5'(9 + i), 1'b1, 64'hC000 + 64'(i), 64'd0, 3'd0, MSZ_B, 1'b0,
                       64'h400 + 64'(4 * i), 64'd0, 1'b1);
         clockCycle();
      end
      checkOutput("t5_retired4", retireCnt, cntBefore + 64'd4);
      idle(1'b1);
      clockCycle();
      clockCycle();

      $display("[TB] reset while stalled");
      applyStimulus(1'b1, WB_ALU, 5'd10, 1'b1, 64'h5555, 64'd0, 3'd0, MSZ_B, 1'b0, 64'h500, 64'd0, 1'b1);
      clockCycle();
      idle(1'b0);
      reset = 1'b1;
      #1;
      checkOutput("t6_rf_we", rfWe, 64'd0);
      checkOutput("t6_commit_valid", commitValid, 64'd1);
      clockCycle();
      reset = 1'b0;
      checkOutput("t6_retire_cnt", retireCnt, 64'd0);
      checkOutput("t6_commit_valid_after", commitValid, 64'd0);
      checkOutput("t6_rf_wdata_after", rfWdata, 64'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(bit'($urandom_range(0, 1)), wb_sel_t'($urandom_range(0, 3)),
                       5'($urandom_range(0, 31)), bit'($urandom_range(0, 3) != 0),
                       {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                       mem_size_t'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                       {$urandom, $urandom}, {$urandom, $urandom},
                       bit'($urandom_range(0, 3) != 0));
         clockCycle();
      end
      idle(1'b1);
      clockCycle();
      clockCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
